// File: rtl/mp_icache_pkg.sv
// Shared types for the cluster icache flush sequencer.
package mp_icache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_FLUSH          = 3'd1,
    ST_FLUSH_WAIT_LOW = 3'd2,
    ST_SEL_FLUSH      = 3'd3,
    ST_SEL_WAIT_LOW   = 3'd4
  } flush_seq_state_e;

endpackage

// File: rtl/mp_icache_flush_seq_if.sv
// Control-unit and bank-side signals of the icache flush sequencer.
interface mp_icache_flush_seq_if #(
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned ADDR_WIDTH = 32
);

  logic                  bypass_req_i;
  logic [NB_BANKS:0]     bypass_ack_o;
  logic                  refill_pending_i;
  logic                  flush_req_i;
  logic                  flush_ack_o;
  logic                  sel_flush_req_i;
  logic [ADDR_WIDTH-1:0] sel_flush_addr_i;
  logic                  sel_flush_ack_o;
  logic [NB_BANKS-1:0]   bank_bypass_req_o;
  logic [NB_BANKS-1:0]   bank_bypass_ack_i;
  logic [NB_BANKS-1:0]   bank_flush_req_o;
  logic [NB_BANKS-1:0]   bank_flush_ack_i;
  logic [NB_BANKS-1:0]   bank_sel_flush_req_o;
  logic [ADDR_WIDTH-1:0] bank_sel_flush_addr_o;
  logic [NB_BANKS-1:0]   bank_sel_flush_ack_i;

  // Control unit plus banks driving the sequencer.
  modport master (
    output bypass_req_i, refill_pending_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
           bank_bypass_ack_i, bank_flush_ack_i, bank_sel_flush_ack_i,
    input  bypass_ack_o, flush_ack_o, sel_flush_ack_o, bank_bypass_req_o,
           bank_flush_req_o, bank_sel_flush_req_o, bank_sel_flush_addr_o
  );

  // The sequencer itself.
  modport slave (
    input  bypass_req_i, refill_pending_i, flush_req_i, sel_flush_req_i, sel_flush_addr_i,
           bank_bypass_ack_i, bank_flush_ack_i, bank_sel_flush_ack_i,
    output bypass_ack_o, flush_ack_o, sel_flush_ack_o, bank_bypass_req_o,
           bank_flush_req_o, bank_sel_flush_req_o, bank_sel_flush_addr_o
  );

endinterface

// File: rtl/mp_icache_bank_hs.sv
// Per-bank request/ack handshake with a sticky done flag cleared on start.
module mp_icache_bank_hs (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic ack_i,
  output logic req_o,
  output logic done_o
);

  logic r_req;
  logic r_done;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_req  <= 1'b0;
      r_done <= 1'b0;
    end else if (start_i) begin
      r_req  <= 1'b1;
      r_done <= 1'b0;
    end else if (ack_i && r_req) begin
      r_req  <= 1'b0;
      r_done <= 1'b1;
    end
  end

  assign req_o  = r_req;
  assign done_o = r_done;

endmodule

// File: rtl/mp_icache_flush_seq.sv
// Broadcasts bypass/flush/selective-flush to all icache banks and aggregates their acks.
module mp_icache_flush_seq
  import mp_icache_pkg::*;
#(
  parameter int unsigned NB_BANKS   = 4,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mp_icache_flush_seq_if.slave bus
);

  flush_seq_state_e r_state, w_state_nxt;

  logic                  w_start;
  logic                  w_latch_addr;
  logic                  w_flush_ack_nxt;
  logic                  w_sel_ack_nxt;
  logic [NB_BANKS-1:0]   w_req;
  logic [NB_BANKS-1:0]   w_done;
  logic [NB_BANKS-1:0]   w_ack_src;
  logic [NB_BANKS-1:0]   w_done_nxt;

  logic                  r_is_sel;
  logic                  r_flush_ack;
  logic                  r_sel_ack;
  logic [ADDR_WIDTH-1:0] r_sel_addr;
  logic                  r_bypass_q;
  logic [NB_BANKS-1:0]   r_bank_bypass_req;
  logic [NB_BANKS:0]     r_bypass_ack;

  // One handshake per bank, shared by full and selective flush.
  for (genvar g = 0; g < NB_BANKS; g++) begin : g_bank
    mp_icache_bank_hs u_hs (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (w_start),
      .ack_i   (w_ack_src[g]),
      .req_o   (w_req[g]),
      .done_o  (w_done[g])
    );
  end

  always_comb begin
    w_ack_src = '0;
    case (r_state)
      ST_FLUSH:     w_ack_src = bus.bank_flush_ack_i;
      ST_SEL_FLUSH: w_ack_src = bus.bank_sel_flush_ack_i;
      default:      w_ack_src = '0;
    endcase
  end

  // Completion is judged on next-cycle done so the last ack is answered one cycle later.
  assign w_done_nxt = w_done | (w_ack_src & w_req);

  always_comb begin
    w_state_nxt     = r_state;
    w_start         = 1'b0;
    w_latch_addr    = 1'b0;
    w_flush_ack_nxt = 1'b0;
    w_sel_ack_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.flush_req_i) begin
          w_state_nxt = ST_FLUSH;
          w_start     = 1'b1;
        end else if (bus.sel_flush_req_i) begin
          w_state_nxt  = ST_SEL_FLUSH;
          w_start      = 1'b1;
          w_latch_addr = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (&w_done_nxt) begin
          w_flush_ack_nxt = 1'b1;
          w_state_nxt     = ST_FLUSH_WAIT_LOW;
        end
      end
      ST_FLUSH_WAIT_LOW: begin
        if (!bus.flush_req_i) w_state_nxt = ST_IDLE;
      end
      ST_SEL_FLUSH: begin
        if (&w_done_nxt) begin
          w_sel_ack_nxt = 1'b1;
          w_state_nxt   = ST_SEL_WAIT_LOW;
        end
      end
      ST_SEL_WAIT_LOW: begin
        if (!bus.sel_flush_req_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_is_sel    <= 1'b0;
      r_flush_ack <= 1'b0;
      r_sel_ack   <= 1'b0;
      r_sel_addr  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_ack <= w_flush_ack_nxt;
      r_sel_ack   <= w_sel_ack_nxt;
      if (w_start) r_is_sel <= w_latch_addr;
      if (w_latch_addr) r_sel_addr <= bus.sel_flush_addr_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bypass_q        <= 1'b0;
      r_bank_bypass_req <= '0;
      r_bypass_ack      <= '0;
    end else begin
      r_bypass_q        <= bus.bypass_req_i;
      r_bank_bypass_req <= {NB_BANKS{bus.bypass_req_i}};
      r_bypass_ack      <= {r_bypass_q & ~bus.refill_pending_i, bus.bank_bypass_ack_i};
    end
  end

  assign bus.bank_bypass_req_o     = r_bank_bypass_req;
  assign bus.bypass_ack_o          = r_bypass_ack;
  assign bus.bank_flush_req_o      = r_is_sel ? '0 : w_req;
  assign bus.bank_sel_flush_req_o  = r_is_sel ? w_req : '0;
  assign bus.bank_sel_flush_addr_o = r_sel_addr;
  assign bus.flush_ack_o           = r_flush_ack;
  assign bus.sel_flush_ack_o       = r_sel_ack;

endmodule

// File: tb/tb_mp_icache_flush_seq.sv
// Directed bench for mp_icache_flush_seq with hand-computed cycle expectations.
module tb_mp_icache_flush_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_total = 0;
  int n_bad   = 0;

  mp_icache_flush_seq_if #(.NB_BANKS(4), .ADDR_WIDTH(32)) bus ();

  mp_icache_flush_seq #(.NB_BANKS(4), .ADDR_WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned ack_c[4];
    logic [3:0] e;
    int pulses;

    bus.bypass_req_i         = 1'b0;
    bus.refill_pending_i     = 1'b0;
    bus.flush_req_i          = 1'b0;
    bus.sel_flush_req_i      = 1'b0;
    bus.sel_flush_addr_i     = '0;
    bus.bank_bypass_ack_i    = '0;
    bus.bank_flush_ack_i     = '0;
    bus.bank_sel_flush_ack_i = '0;

    // Reset state
    tick();
    tick();
    chk("rst_bypass_ack", 64'(bus.bypass_ack_o), 64'h0);
    chk("rst_bank_byp_req", 64'(bus.bank_bypass_req_o), 64'h0);
    chk("rst_flush_req", 64'(bus.bank_flush_req_o), 64'h0);
    chk("rst_sel_req", 64'(bus.bank_sel_flush_req_o), 64'h0);
    chk("rst_addr", 64'(bus.bank_sel_flush_addr_o), 64'h0);
    chk("rst_acks", 64'({bus.flush_ack_o, bus.sel_flush_ack_o}), 64'h0);
    rst = 1'b0;
    tick();

    // Bypass: banks ack from cycle 3, refill later goes pending
    bus.bypass_req_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.bank_bypass_ack_i = (c >= 3) ? 4'hF : 4'h0;
      bus.refill_pending_i  = (c >= 5);
      chk($sformatf("byp_req_c%0d", c), 64'(bus.bank_bypass_req_o), (c >= 1) ? 64'hF : 64'h0);
      case (c)
        0, 1:    chk($sformatf("byp_ack_c%0d", c), 64'(bus.bypass_ack_o), 64'h00);
        2, 3:    chk($sformatf("byp_ack_c%0d", c), 64'(bus.bypass_ack_o), 64'h10);
        4, 5:    chk($sformatf("byp_ack_c%0d", c), 64'(bus.bypass_ack_o), 64'h1F);
        default: chk($sformatf("byp_ack_c%0d", c), 64'(bus.bypass_ack_o), 64'h0F);
      endcase
      tick();
    end
    bus.bypass_req_i      = 1'b0;
    bus.bank_bypass_ack_i = '0;
    bus.refill_pending_i  = 1'b0;
    tick();
    tick();
    chk("byp_off_ack", 64'(bus.bypass_ack_o), 64'h0);
    chk("byp_off_req", 64'(bus.bank_bypass_req_o), 64'h0);

    // Full flush, bank acks at 3,5,5,9; held 4 cycles after the ack
    ack_c = '{3, 5, 5, 9};
    pulses = 0;
    bus.flush_req_i = 1'b1;
    for (int c = 0; c < 15; c++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        bus.bank_flush_ack_i[i] = (c == int'(ack_c[i]));
        e[i] = (c >= 1) && (c <= int'(ack_c[i]));
      end
      chk($sformatf("fl_req_c%0d", c), 64'(bus.bank_flush_req_o), 64'(e));
      chk($sformatf("fl_ack_c%0d", c), 64'(bus.flush_ack_o), (c == 10) ? 64'h1 : 64'h0);
      chk($sformatf("fl_selreq_c%0d", c), 64'(bus.bank_sel_flush_req_o), 64'h0);
      if (bus.flush_ack_o) pulses++;
      if (c == 14) bus.flush_req_i = 1'b0;
      tick();
    end
    bus.bank_flush_ack_i = '0;
    chk("fl_pulses", 64'(pulses), 64'h1);

    // Selective flush; address input changes after the latch
    bus.sel_flush_req_i  = 1'b1;
    bus.sel_flush_addr_i = 32'h1C00_8040;
    ack_c = '{2, 2, 4, 4};
    pulses = 0;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) bus.sel_flush_addr_i = 32'hDEAD_BEEF;
      for (int unsigned i = 0; i < 4; i++) begin
        bus.bank_sel_flush_ack_i[i] = (c == int'(ack_c[i])) || (c == 3 && i == 0);
        e[i] = (c >= 1) && (c <= int'(ack_c[i]));
      end
      chk($sformatf("sel_req_c%0d", c), 64'(bus.bank_sel_flush_req_o), 64'(e));
      chk($sformatf("sel_ack_c%0d", c), 64'(bus.sel_flush_ack_o), (c == 5) ? 64'h1 : 64'h0);
      chk($sformatf("sel_flreq_c%0d", c), 64'(bus.bank_flush_req_o), 64'h0);
      if (c >= 1 && c <= 4)
        chk($sformatf("sel_addr_c%0d", c), 64'(bus.bank_sel_flush_addr_o), 64'h1C00_8040);
      if (bus.sel_flush_ack_o) pulses++;
      if (c == 5) bus.sel_flush_req_i = 1'b0;
      tick();
    end
    bus.bank_sel_flush_ack_i = '0;
    chk("sel_pulses", 64'(pulses), 64'h1);

    // Both requests in the same cycle: full flush first, then selective
    bus.flush_req_i      = 1'b1;
    bus.sel_flush_req_i  = 1'b1;
    bus.sel_flush_addr_i = 32'h0000_1234;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      bus.bank_flush_ack_i     = (c == 2) ? 4'hF : 4'h0;
      bus.bank_sel_flush_ack_i = (c == 6) ? 4'hF : 4'h0;
      if (c == 3) bus.flush_req_i = 1'b0;
      if (c == 7) bus.sel_flush_req_i = 1'b0;
      chk($sformatf("both_flreq_c%0d", c), 64'(bus.bank_flush_req_o),
          (c == 1 || c == 2) ? 64'hF : 64'h0);
      chk($sformatf("both_selreq_c%0d", c), 64'(bus.bank_sel_flush_req_o),
          (c == 5 || c == 6) ? 64'hF : 64'h0);
      chk($sformatf("both_flack_c%0d", c), 64'(bus.flush_ack_o), (c == 3) ? 64'h1 : 64'h0);
      chk($sformatf("both_selack_c%0d", c), 64'(bus.sel_flush_ack_o), (c == 7) ? 64'h1 : 64'h0);
      if (c == 5) chk("both_addr", 64'(bus.bank_sel_flush_addr_o), 64'h0000_1234);
      pulses += int'(bus.flush_ack_o) + int'(bus.sel_flush_ack_o);
      tick();
    end
    bus.bank_flush_ack_i     = '0;
    bus.bank_sel_flush_ack_i = '0;
    chk("both_pulses", 64'(pulses), 64'h2);

    // Spurious bank ack in IDLE
    bus.bank_flush_ack_i = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("spur_ack_c%0d", c), 64'(bus.flush_ack_o), 64'h0);
      chk($sformatf("spur_req_c%0d", c), 64'(bus.bank_flush_req_o), 64'h0);
    end
    bus.bank_flush_ack_i = '0;

    // Reset in the middle of a flush
    bus.flush_req_i = 1'b1;
    tick();
    chk("mid_req_c1", 64'(bus.bank_flush_req_o), 64'hF);
    bus.bank_flush_ack_i = 4'b0001;
    tick();
    bus.bank_flush_ack_i = '0;
    chk("mid_req_c2", 64'(bus.bank_flush_req_o), 64'hE);
    #2;
    rst = 1'b1;
    bus.flush_req_i = 1'b0;
    #1;
    chk("mid_rst_req", 64'(bus.bank_flush_req_o), 64'h0);
    chk("mid_rst_ack", 64'(bus.flush_ack_o), 64'h0);
    tick();
    rst = 1'b0;
    bus.bank_flush_ack_i = 4'b1110;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("post_rst_ack_c%0d", c), 64'(bus.flush_ack_o), 64'h0);
      chk($sformatf("post_rst_req_c%0d", c), 64'(bus.bank_flush_req_o), 64'h0);
    end
    bus.bank_flush_ack_i = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
